ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_sync.sv | 35 +++
 rtl/ps2_host_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host blocks.
//   ps2_tx_state_e     : host-to-device transmit FSM states
//   INHIBIT_CYCLES_DEF : default clock-inhibit length (100 us at 50 MHz)
//   TIMEOUT_CYCLES_DEF : default transaction timeout (15 ms at 50 MHz)
//   FRAME_LEN          : start + 8 data + parity + stop
//   odd_parity()       : parity bit that makes the 9-bit data+parity odd
package ps2_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAITIDLE, S_DONE, S_ERR
  } ps2_tx_state_e;

  localparam int INHIBIT_CYCLES_DEF = 5000;
  localparam int TIMEOUT_CYCLES_DEF = 750000;
  localparam int FRAME_LEN          = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_sync.sv
// ps2_sync -- 3-flop synchronizers for the PS/2 clock and data lines plus
// falling-edge detect on the synchronized clock. Shared with the receiver.
//   clk, resetn   : system clock, async active-low reset
//   i_ps2_clk     : raw PS/2 clock line
//   i_ps2_data    : raw PS/2 data line
//   o_clk_s       : synchronized clock level
//   o_data_s      : synchronized data level
//   o_clk_fall    : one-cycle pulse on a synchronized clock falling edge
module ps2_sync (
  input  logic clk,
  input  logic resetn,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_s,
  output logic o_data_s,
  output logic o_clk_fall
);
  logic [2:0] r_clk_sync;
  logic [2:0] r_data_sync;

  // Reset to 1 (idle bus) so leaving reset never fakes a falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[1:0], i_ps2_data};
    end
  end

  assign o_clk_s    = r_clk_sync[2];
  assign o_data_s   = r_data_sync[2];
  assign o_clk_fall = r_clk_sync[2] & ~r_clk_sync[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
// Inhibits the bus, issues the request-to-send, shifts out an 11-bit frame
// on device clock falling edges, checks the device ACK and waits for idle.
//   clk, resetn          : system clock, async active-low reset
//   ps2_clk, ps2_data    : raw bus line levels (asynchronous)
//   ps2_clk_low          : 1 = pull clock line low
//   ps2_data_low         : 1 = pull data line low
//   tx_valid/tx_data     : command byte request
//   tx_ready             : idle, request accepted on tx_valid & tx_ready
//   tx_done / tx_err     : one-cycle completion / failure pulses
// Optional: define PS2_TX_TIMEOUT_EN to abort stalled transactions after
// TIMEOUT_CYCLES counted from entry into REQ.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

  logic w_clk_s, w_data_s, w_clk_fall;

  ps2_sync u_sync (
    .clk       (clk),
    .resetn    (resetn),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_clk_s   (w_clk_s),
    .o_data_s  (w_data_s),
    .o_clk_fall(w_clk_fall)
  );

  ps2_tx_state_e          r_state, w_state_nxt;
  logic [IW-1:0]          r_inh_cnt, w_inh_cnt_nxt;
  logic [3:0]             r_bit_cnt, w_bit_cnt_nxt;
  logic [FRAME_LEN-1:0]   r_frame, w_frame_nxt;
  logic r_clk_low, r_data_low, r_ready, r_done, r_err;
  logic w_clk_low_nxt, w_data_low_nxt;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_inh_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_frame    <= '0;
      r_clk_low  <= 1'b0;
      r_data_low <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inh_cnt  <= w_inh_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_frame    <= w_frame_nxt;
      r_clk_low  <= w_clk_low_nxt;
      r_data_low <= w_data_low_nxt;
      r_ready    <= (w_state_nxt == S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      r_err      <= (w_state_nxt == S_ERR);
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_to_cnt <= '0;
    else         r_to_cnt <= w_to_cnt_nxt;
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_inh_cnt_nxt = r_inh_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_frame_nxt   = r_frame;
    unique case (r_state)
      S_IDLE: if (tx_valid && r_ready) begin
        // frame[0] is the start bit, frame[k] is driven after falling edge k
        w_frame_nxt   = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
        w_inh_cnt_nxt = '0;
        w_bit_cnt_nxt = '0;
        w_state_nxt   = S_INHIBIT;
      end
      S_INHIBIT: begin
        if (r_inh_cnt == INH_LAST) w_state_nxt = S_REQ;
        else                       w_inh_cnt_nxt = r_inh_cnt + IW'(1);
      end
      S_REQ: w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_clk_fall) begin
        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
        if (r_bit_cnt == 4'(FRAME_LEN - 2)) w_state_nxt = S_ACK;
      end
      S_ACK:      if (w_clk_fall) w_state_nxt = w_data_s ? S_ERR : S_WAITIDLE;
      S_WAITIDLE: if (w_clk_s && w_data_s) w_state_nxt = S_DONE;
      S_DONE, S_ERR: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    w_to_cnt_nxt = r_to_cnt;
    if (r_state == S_INHIBIT) begin
      w_to_cnt_nxt = '0;
    end else if (r_state == S_REQ || r_state == S_SHIFT ||
                 r_state == S_ACK || r_state == S_WAITIDLE) begin
      // Overrides any in-progress transition, including a same-cycle ACK.
      if (r_to_cnt == TO_LAST) w_state_nxt = S_ERR;
      else                     w_to_cnt_nxt = r_to_cnt + TW'(1);
    end
`endif

    // Outputs are registered from the state being entered, so they line up
    // with the state register instead of lagging it by a cycle.
    w_clk_low_nxt  = (w_state_nxt == S_INHIBIT);
    w_data_low_nxt = 1'b0;
    case (w_state_nxt)
      S_INHIBIT:             w_data_low_nxt = (w_inh_cnt_nxt == INH_LAST);
      S_REQ, S_SHIFT, S_ACK: w_data_low_nxt = ~w_frame_nxt[w_bit_cnt_nxt];
      default:               w_data_low_nxt = 1'b0;
    endcase
  end

  assign ps2_clk_low  = r_clk_low;
  assign ps2_data_low = r_data_low;
  assign tx_ready     = r_ready;
  assign tx_done      = r_done;
  assign tx_err       = r_err;
endmodule
